// File: rtl/alu_issue_pkg.sv
//------------------------------------------------------------------------------
// Module : alu_issue_pkg
// Brief  : Opcode encodings and result-entry field widths for the ALU issue stage.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_issue_pkg;

    localparam int OP_W   = 3;
    localparam int FLAG_W = 3;  // carry, zero, err

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_GT  = 3'd5;

    // Entry layout, MSB first: {op, err, zero, carry, result}
    function automatic int entry_width(input int width);
        return width + FLAG_W + OP_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_result_fifo.sv
//------------------------------------------------------------------------------
// Module : alu_result_fifo
// Brief  : Generic synchronous circular-buffer FIFO with occupancy count.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_result_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 2
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      i_push,
    input  wire logic [DATA_W-1:0]         i_wdata,
    input  wire logic                      i_pop,
    output logic      [DATA_W-1:0]         o_rdata,
    output logic      [$clog2(DEPTH):0]    o_count,
    output logic                           o_full,
    output logic                           o_empty
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = DEPTH[c_aw:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]     count_q, count_d;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (count_q == c_depth);
    assign o_empty   = (count_q == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = mem_q[rd_ptr_q];
    assign o_count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head never reads X.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
//------------------------------------------------------------------------------
// Module : alu_issue_stage
// Brief  : Valid/ready issue stage evaluating ALU ops into a flagged result FIFO.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     in_valid,
    output logic                          in_ready,
    input  wire logic [2:0]               in_op,
    input  wire logic [WIDTH-1:0]         in_a,
    input  wire logic [WIDTH-1:0]         in_b,
    output logic                          out_valid,
    input  wire logic                     out_ready,
    output logic      [WIDTH-1:0]         out_result,
    output logic                          out_carry,
    output logic                          out_zero,
    output logic                          out_err,
    output logic      [2:0]               out_op,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int c_entry_w = entry_width(WIDTH);

    logic [WIDTH:0]         w_sum;
    logic [WIDTH-1:0]       w_res;
    logic                   w_carry;
    logic                   w_zero;
    logic                   w_err;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [c_entry_w-1:0]   w_wdata;
    logic [c_entry_w-1:0]   w_head;

    always_comb begin
        w_sum   = {1'b0, in_a} + {1'b0, in_b};
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (in_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res   = in_a - in_b;
                w_carry = (in_a < in_b);
            end
            OP_AND:  w_res = in_a & in_b;
            OP_OR:   w_res = in_a | in_b;
            OP_XOR:  w_res = in_a ^ in_b;
            OP_GT:   w_res = (in_a > in_b) ? '1 : '0;
            default: w_err = 1'b1;
        endcase
        w_zero = (w_res == '0);
    end

    // in_ready depends only on reset and registered occupancy, never on out_ready.
    assign in_ready  = ~rst & ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_wdata   = {in_op, w_err, w_zero, w_carry, w_res};

    alu_result_fifo #(
        .DATA_W (c_entry_w),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {out_op, out_err, out_zero, out_carry, out_result} = w_head;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
//------------------------------------------------------------------------------
// Module : tb_alu_issue_stage
// Brief  : Self-checking bench: vector table, corner sequences, random scoreboard.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic       out_err;
    logic [2:0] out_op;
    logic [1:0] count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_err    (out_err),
        .out_op     (out_op),
        .count      (count)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       e;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {op, err, zero, carry, result}
    function automatic logic [9:0] model(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        int         s;
        logic [3:0] r;
        logic       c;
        logic       e;
        r = 4'h0; c = 1'b0; e = 1'b0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r = s[3:0]; c = (s > 15); end
            3'd1: begin s = int'(a) - int'(b) + 16; r = s[3:0]; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (a > b) ? 4'hF : 4'h0;
            default: e = 1'b1;
        endcase
        return {op, e, (r == 4'h0), c, r};
    endfunction

    function automatic logic [9:0] head();
        return {out_op, out_err, out_zero, out_carry, out_result};
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b);
        in_valid = v; in_op = op; in_a = a; in_b = b;
    endtask

    logic [9:0] q[$];
    logic [9:0] prev_head;
    logic [9:0] exp_e;
    logic       stalled;
    logic       do_push;
    logic       do_pop;

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        drive(1'b0, 3'd0, 4'h0, 4'h0);

        vecs[0]  = '{3'd0, 4'h9, 4'h8, 4'h1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3'd1, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'd1, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{3'd1, 4'h9, 4'h2, 4'h7, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd2, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd3, 4'hC, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd4, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'd4, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'd5, 4'h7, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'd5, 4'h2, 4'h7, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{3'd5, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{3'd6, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{3'd7, 4'h1, 4'h2, 4'h0, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_head", 32'(head()), 32'd0);

        // Vector table: one request at a time, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            drive(1'b0, 3'd0, 4'h0, 4'h0);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'd1);
            chk($sformatf("vec%0d_head", i), 32'(head()),
                32'({vecs[i].op, vecs[i].e, vecs[i].z, vecs[i].c, vecs[i].res}));
            tick();
            chk($sformatf("vec%0d_drain", i), 32'(count), 32'd0);
        end

        // Fill to full, hold third request, drain
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 4'h3, 4'h5);
        tick();
        drive(1'b1, 3'd5, 4'h7, 4'h2);
        tick();
        chk("full_count", 32'(count), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 3'd5, 4'h2, 4'h7);
        tick();
        chk("held_count", 32'(count), 32'd2);
        chk("stall_head_res", 32'(out_result), 32'hE);
        chk("stall_head_carry", 32'(out_carry), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("full_pop_no_early_ready", 32'(in_ready), 32'd0);
        tick();
        chk("drain1_count", 32'(count), 32'd1);
        chk("drain1_head", 32'(head()), 32'(model(3'd5, 4'h7, 4'h2)));
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("pushpop_count", 32'(count), 32'd1);
        chk("pushpop_valid", 32'(out_valid), 32'd1);
        chk("pushpop_res", 32'(out_result), 32'h0);
        chk("pushpop_zero", 32'(out_zero), 32'd1);
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Back-to-back stream at full throughput
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'($urandom_range(0, 5)), 4'($urandom), 4'($urandom));
            exp_e = model(in_op, in_a, in_b);
            tick();
            chk($sformatf("stream%0d_head", i), 32'(head()), 32'(exp_e));
            chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
        end
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        tick();
        chk("stream_end_count", 32'(count), 32'd0);

        // Mid-stream reset with a full FIFO and a pending request
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 4'h1, 4'h1);
        tick();
        drive(1'b1, 3'd0, 4'h2, 4'h2);
        tick();
        chk("prerst_count", 32'(count), 32'd2);
        drive(1'b1, 3'd0, 4'h3, 4'h3);
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_hi_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_head", 32'(head()), 32'd0);
        rst = 1'b0;
        drive(1'b0, 3'd0, 4'h0, 4'h0);
        #1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        tick();
        chk("midrst_dropped", 32'(count), 32'd0);

        // Random traffic against a scoreboard
        stalled = 1'b0;
        prev_head = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom),
                  4'($urandom));
            out_ready = 1'($urandom_range(0, 2) == 0 ? 0 : 1);
            #1;
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            if (stalled) chk("rnd_stable", 32'(head()), 32'(prev_head));
            do_push = in_valid & in_ready;
            do_pop  = out_valid & out_ready;
            if (do_pop) begin
                if (q.size() == 0) chk("rnd_underflow", 32'd1, 32'd0);
                else chk("rnd_order", 32'(head()), 32'(q.pop_front()));
            end
            if (do_push) q.push_back(model(in_op, in_a, in_b));
            stalled   = out_valid & ~out_ready;
            prev_head = head();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
